// File: rtl/cpu_dmem_pkg.sv
// Shared constants and types for the CPU data-memory responder.
// I/O register offsets, STATUS bit positions, timer FSM and address-region encodings.
package cpu_dmem_pkg;

  localparam logic [3:0] OFF_LED    = 4'h0;
  localparam logic [3:0] OFF_CYCLES = 4'h4;
  localparam logic [3:0] OFF_TIMER  = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_ERR  = 1;

  typedef enum logic {
    TMR_IDLE,
    TMR_RUN
  } tmr_state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_e;

endpackage

// File: rtl/cpu_dmem_responder_timer.sv
// Countdown timer: a load sets the count and starts it; done_o pulses on the edge where it reaches 0.
// A load always wins over the decrement; loading 0 stops the timer without a done pulse.
module dmem_timer
  import cpu_dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] count_o,
  output logic        done_o
);

  tmr_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TMR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    if (load_i) begin
      cnt_d   = load_val_i;
      state_d = (load_val_i != '0) ? TMR_RUN : TMR_IDLE;
    end else if (state_q == TMR_RUN) begin
      if (cnt_q == 32'd1) begin
        cnt_d   = '0;
        state_d = TMR_IDLE;
        done_o  = 1'b1;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/cpu_dmem_responder.sv
// Data-port responder: word RAM plus LED / cycle counter / timer / STATUS I/O window.
// Reads are combinational from ALUResult; stores commit on the rising clk edge.
module cpu_dmem_responder
  import cpu_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] IO_BASE     = 32'h0000_1000,
  parameter int unsigned LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWrite,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] led_out,
  output logic             timer_irq,
  output logic             bus_err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      cyc_q;
  logic [LED_W-1:0] led_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      tmr_count;
  logic             tmr_done;

  region_e    region;
  logic [3:0] off;
  logic       mis, wr_ok, bad_wr;
  logic       wr_ram, wr_led, wr_timer, wr_status;

  // The I/O window is assumed 16-byte aligned, so the upper 28 bits select it.
  always_comb begin
    if (ALUResult < RAM_BYTES)               region = REG_RAM;
    else if (ALUResult[31:4] == IO_BASE[31:4]) region = REG_IO;
    else                                     region = REG_NONE;
  end

  assign off       = ALUResult[3:0];
  assign mis       = |ALUResult[1:0];
  assign wr_ok     = MemWrite && !mis;
  assign bad_wr    = MemWrite && (mis || region == REG_NONE);
  assign wr_ram    = wr_ok && region == REG_RAM;
  assign wr_led    = wr_ok && region == REG_IO && off == OFF_LED;
  assign wr_timer  = wr_ok && region == REG_IO && off == OFF_TIMER;
  assign wr_status = wr_ok && region == REG_IO && off == OFF_STATUS;

  always_comb begin
    ReadData = '0;
    if (!mis) begin
      case (region)
        REG_RAM: ReadData = mem_q[ALUResult[AW+1:2]];
        REG_IO: begin
          case (off)
            OFF_LED:    ReadData = 32'(led_q);
            OFF_CYCLES: ReadData = cyc_q;
            OFF_TIMER:  ReadData = tmr_count;
            OFF_STATUS: begin
              ReadData[STAT_DONE] = done_q;
              ReadData[STAT_ERR]  = err_q;
            end
            default: ReadData = '0;
          endcase
        end
        default: ReadData = '0;
      endcase
    end
  end

  // RAM has no reset; stores arriving while reset is asserted are discarded.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ram) mem_q[ALUResult[AW+1:2]] <= WriteData;
  end

  // Hardware sets are applied after W1C clears so a coincident set survives.
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    if (wr_status) begin
      if (WriteData[STAT_DONE]) done_d = 1'b0;
      if (WriteData[STAT_ERR])  err_d  = 1'b0;
    end
    if (tmr_done) done_d = 1'b1;
    if (bad_wr)   err_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      led_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cyc_q  <= cyc_q + 32'd1;
      done_q <= done_d;
      err_q  <= err_d;
      if (wr_led) led_q <= WriteData[LED_W-1:0];
    end
  end

  dmem_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wr_timer),
    .load_val_i (WriteData),
    .count_o    (tmr_count),
    .done_o     (tmr_done)
  );

  assign led_out   = led_q;
  assign timer_irq = done_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_cpu_dmem_responder.sv
// Directed bench for cpu_dmem_responder: expectations queued with each stimulus, popped at observation.
module tb_cpu_dmem_responder;

  localparam logic [31:0] IO = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  led_out;
  logic        timer_irq;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  string       tag_q[$];
  logic [31:0] val_q[$];

  cpu_dmem_responder #(
    .DEPTH_WORDS (256),
    .IO_BASE     (IO),
    .LED_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .led_out   (led_out),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic put(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (tag_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed %h required an expectation", obs);
      return;
    end
    t = tag_q.pop_front();
    e = val_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    ALUResult = a;
    WriteData = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    put("rst_led", 32'h0);  chk(32'(led_out));
    put("rst_irq", 32'h0);  chk(32'(timer_irq));
    put("rst_err", 32'h0);  chk(32'(bus_err));
    drive(1'b0, IO + 32'h8, 32'h0);
    put("rst_timer", 32'h0); chk(ReadData);
    drive(1'b0, IO + 32'h4, 32'h0);
    put("rst_cycles", 32'h0); chk(ReadData);

    // Cycle counter: 10 edges after release
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    put("cycles_10", 32'd10); chk(ReadData);

    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    put("cycles_forced", 32'hFFFF_FFFF); chk(ReadData);
    release dut.cyc_q;
    step();
    put("cycles_wrap", 32'h0); chk(ReadData);

    // RAM store/load, old value visible during the write cycle
    drive(1'b1, 32'd12, 32'd7);
    step();
    drive(1'b1, 32'd12, 32'd16);
    put("ram_old_during_wr", 32'd7); chk(ReadData);
    step();
    drive(1'b0, 32'd12, 32'h0);
    put("ram_rd12", 32'd16); chk(ReadData);
    drive(1'b1, 32'd1020, 32'hCAFE_F00D);
    step();
    drive(1'b0, 32'd1020, 32'h0);
    put("ram_top_word", 32'hCAFE_F00D); chk(ReadData);
    drive(1'b0, 32'd1024, 32'h0);
    put("ram_past_end_rd", 32'h0); chk(ReadData);
    step();
    put("rd_no_side_effect", 32'h0); chk(32'(bus_err));

    // LED register
    drive(1'b1, IO, 32'h0000_01A5);
    put("led_before_edge", 32'h0); chk(32'(led_out));
    step();
    put("led_out", 32'hA5); chk(32'(led_out));
    drive(1'b0, IO, 32'h0);
    put("led_rd", 32'h0000_00A5); chk(ReadData);

    // Timer countdown 3,2,1 then done
    drive(1'b1, IO + 32'h8, 32'd3);
    step();
    drive(1'b0, IO + 32'h8, 32'h0);
    put("timer_3", 32'd3); chk(ReadData);
    step();
    put("timer_2", 32'd2); chk(ReadData);
    step();
    put("timer_1", 32'd1); chk(ReadData);
    put("irq_before_done", 32'h0); chk(32'(timer_irq));
    step();
    put("timer_0", 32'd0); chk(ReadData);
    put("irq_done", 32'h1); chk(32'(timer_irq));
    drive(1'b0, IO + 32'hC, 32'h0);
    put("status_done", 32'h1); chk(ReadData);
    drive(1'b1, IO + 32'hC, 32'h1);
    step();
    drive(1'b0, IO + 32'hC, 32'h0);
    put("irq_w1c", 32'h0); chk(32'(timer_irq));

    // Write 0 during RUN aborts without done
    drive(1'b1, IO + 32'h8, 32'd5);
    step();
    drive(1'b1, IO + 32'h8, 32'd0);
    step();
    drive(1'b0, IO + 32'h8, 32'h0);
    put("timer_abort", 32'h0); chk(ReadData);
    step();
    step();
    put("timer_abort_still0", 32'h0); chk(ReadData);
    put("abort_no_irq", 32'h0); chk(32'(timer_irq));

    // Bus errors
    drive(1'b1, 32'd14, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 32'd12, 32'h0);
    put("err_misaligned", 32'h1); chk(32'(bus_err));
    put("ram_unchanged", 32'd16); chk(ReadData);
    drive(1'b0, 32'd14, 32'h0);
    put("misaligned_rd_zero", 32'h0); chk(ReadData);
    put("led_unchanged", 32'hA5); chk(32'(led_out));
    drive(1'b1, IO + 32'hC, 32'h2);
    step();
    put("err_w1c", 32'h0); chk(32'(bus_err));
    drive(1'b1, 32'h2000, 32'h5);
    step();
    put("err_unmapped", 32'h1); chk(32'(bus_err));
    drive(1'b0, IO + 32'hC, 32'h0);
    put("status_err", 32'h2); chk(ReadData);
    drive(1'b1, IO + 32'hC, 32'h2);
    step();
    drive(1'b1, 32'd1024, 32'h1);
    step();
    put("err_ram_boundary", 32'h1); chk(32'(bus_err));
    drive(1'b1, IO + 32'hD, 32'h2);
    step();
    put("err_misaligned_w1c", 32'h1); chk(32'(bus_err));

    // done set coinciding with a W1C of done leaves it set
    drive(1'b1, IO + 32'h8, 32'd1);
    step();
    drive(1'b1, IO + 32'hC, 32'h1);
    step();
    drive(1'b0, IO + 32'h8, 32'h0);
    put("done_set_wins", 32'h1); chk(32'(timer_irq));
    put("timer_after_done", 32'h0); chk(ReadData);
    put("err_kept", 32'h1); chk(32'(bus_err));

    // Asynchronous reset mid-count
    drive(1'b1, IO + 32'h8, 32'd100);
    step();
    drive(1'b0, IO + 32'h8, 32'h0);
    put("timer_100", 32'd100); chk(ReadData);
    #2;
    rst_n = 1'b0;
    #1;
    put("arst_led", 32'h0);   chk(32'(led_out));
    put("arst_irq", 32'h0);   chk(32'(timer_irq));
    put("arst_err", 32'h0);   chk(32'(bus_err));
    put("arst_timer", 32'h0); chk(ReadData);
    drive(1'b1, IO, 32'hFF);
    step();
    drive(1'b0, IO + 32'h8, 32'h0);
    rst_n = 1'b1;
    step();
    step();
    step();
    put("post_rst_timer", 32'h0); chk(ReadData);
    put("post_rst_irq", 32'h0);   chk(32'(timer_irq));
    put("write_in_rst_lost", 32'h0); chk(32'(led_out));

    if (tag_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed %0d entries required 0", tag_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
